// File: rtl/axis_cmd_packer.sv
// rtl/axis_cmd_packer.sv - host command to instruction-packet AXI-Stream encoder
//
// Purpose: turns RUN / APPLY_SPIKE / CLR / APPLY_PERIODIC commands into
// INP_WIDTH-bit instruction packets on a registered AXI-Stream master. RUN
// counts above the RUN field maximum are split into several RUN packets. The
// block also tracks timesteps issued but not yet answered by an output beat.
//
// Ports:
//   clk, arst                    clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_op, cmd_arg, cmd_count   opcode, pre-packed payload, RUN step count
//   m_axis_tdata/tvalid/tready   instruction packet stream to the processor
//   out_beat                     processor result handshake tap
//   pending_steps                issued timesteps awaiting an out_beat
//   busy                         splitting or holding an unsent packet
//   err_underflow                sticky: out_beat seen with nothing pending
module axis_cmd_packer #(
  parameter int INP_WIDTH = 16,
  parameter int RUN_WIDTH = INP_WIDTH - 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [INP_WIDTH-2:0] cmd_arg,
  input  logic [CNT_WIDTH-1:0] cmd_count,
  output logic [INP_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  input  logic                 out_beat,
  output logic [CNT_WIDTH-1:0] pending_steps,
  output logic                 busy,
  output logic                 err_underflow
);

  localparam logic [1:0] OP_RUN      = 2'd0;
  localparam logic [1:0] OP_SPIKE    = 2'd1;
  localparam logic [1:0] OP_CLR      = 2'd2;
  localparam logic [1:0] OP_PERIODIC = 2'd3;

  localparam logic [CNT_WIDTH-1:0] RUN_MAX = CNT_WIDTH'({RUN_WIDTH{1'b1}});

  typedef enum logic {ST_IDLE, ST_SPLIT} state_t;

  state_t               r_state;
  logic                 r_tvalid;
  logic [INP_WIDTH-1:0] r_tdata;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_pending;
  logic                 r_err;

  logic                 w_hs;
  logic                 w_accept;
  logic                 w_run_hs;
  logic [CNT_WIDTH-1:0] w_add;
  logic [RUN_WIDTH-1:0] w_first_chunk;
  logic [CNT_WIDTH-1:0] w_split_chunk;
  logic [CNT_WIDTH-1:0] w_remaining_next;

  assign w_hs      = r_tvalid && m_axis_tready;
  assign cmd_ready = (r_state == ST_IDLE) && (!r_tvalid || m_axis_tready) && !arst;
  assign w_accept  = cmd_valid && cmd_ready;

  // Only RUN packets carry the 001 prefix (PERIODIC has MSB=1, SPIKE/CLR 01x),
  // so the packet being handshaken identifies itself; no side flag needed.
  assign w_run_hs = w_hs && (r_tdata[INP_WIDTH-1 -: 3] == 3'b001);
  assign w_add    = w_run_hs ? CNT_WIDTH'(r_tdata[RUN_WIDTH-1:0]) : '0;

  assign w_first_chunk    = (cmd_count > RUN_MAX) ? {RUN_WIDTH{1'b1}} : cmd_count[RUN_WIDTH-1:0];
  assign w_split_chunk    = (r_remaining > RUN_MAX) ? RUN_MAX : r_remaining;
  assign w_remaining_next = r_remaining - w_split_chunk;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign pending_steps = r_pending;
  assign err_underflow = r_err;
  assign busy          = (r_state != ST_IDLE) || r_tvalid;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= ST_IDLE;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_remaining <= '0;
      r_pending   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          unique case (cmd_op)
            OP_RUN: begin
              if (cmd_count == '0) begin
                // Nothing to send; acceptance implies any held packet is gone.
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
              end else begin
                r_tvalid <= 1'b1;
                r_tdata  <= {3'b001, w_first_chunk};
                if (cmd_count > RUN_MAX) begin
                  r_remaining <= cmd_count - RUN_MAX;
                  r_state     <= ST_SPLIT;
                end
              end
            end
            OP_SPIKE: begin
              r_tvalid <= 1'b1;
              r_tdata  <= {3'b010, cmd_arg[INP_WIDTH-4:0]};
            end
            OP_CLR: begin
              r_tvalid <= 1'b1;
              r_tdata  <= {3'b011, {(INP_WIDTH-3){1'b0}}};
            end
            OP_PERIODIC: begin
              r_tvalid <= 1'b1;
              r_tdata  <= {1'b1, cmd_arg};
            end
          endcase
        end else if (w_hs) begin
          r_tvalid <= 1'b0;
        end
      end else begin
        // SPLIT keeps tvalid high; each handshake loads the next chunk.
        if (w_hs) begin
          r_tdata     <= {3'b001, w_split_chunk[RUN_WIDTH-1:0]};
          r_remaining <= w_remaining_next;
          if (w_remaining_next == '0) begin
            r_state <= ST_IDLE;
          end
        end
      end

      // A RUN handshake always adds at least 1, so only a bare beat underflows.
      if (out_beat && (r_pending == '0) && !w_run_hs) begin
        r_err <= 1'b1;
      end else begin
        r_pending <= r_pending + w_add - CNT_WIDTH'(out_beat);
      end
    end
  end

endmodule

// File: tb/tb_axis_cmd_packer.sv
// tb/tb_axis_cmd_packer.sv - self-checking bench for axis_cmd_packer
module tb_axis_cmd_packer;

  localparam int RMAX = 8191;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [14:0] cmd_arg = '0;
  logic [31:0] cmd_count = '0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        out_beat = 1'b0;
  logic [31:0] pending_steps;
  logic        busy;
  logic        err_underflow;

  always #5 clk = ~clk;

  axis_cmd_packer #(.INP_WIDTH(16), .RUN_WIDTH(13), .CNT_WIDTH(32)) dut (
    .clk(clk), .arst(arst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_count(cmd_count),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .out_beat(out_beat), .pending_steps(pending_steps),
    .busy(busy), .err_underflow(err_underflow)
  );

  // Model: queue of every packet still owed to the stream, in order.
  logic [15:0] exp_q[$];
  logic [31:0] m_pend = '0;
  logic        m_err = 1'b0;
  logic [15:0] hs_log[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [14:0] arg, input logic [31:0] cnt);
    logic [31:0] n;
    logic [31:0] c;
    case (op)
      2'd0: begin
        n = cnt;
        while (n != 0) begin
          c = (n > RMAX) ? RMAX : n;
          exp_q.push_back({3'b001, c[12:0]});
          n = n - c;
        end
      end
      2'd1: exp_q.push_back({3'b010, arg[12:0]});
      2'd2: exp_q.push_back(16'h6000);
      default: exp_q.push_back({1'b1, arg});
    endcase
  endtask

  task automatic step(input logic v, input logic [1:0] op, input logic [14:0] arg,
                      input logic [31:0] cnt, input logic rdy, input logic ob);
    logic        exp_ready;
    logic        hs;
    logic [31:0] add;
    logic [15:0] pkt;
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; cmd_count = cnt;
    m_axis_tready = rdy; out_beat = ob;
    #1;
    exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
    chk("tvalid", m_axis_tvalid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("tdata", m_axis_tdata, exp_q[0]);
    chk("cmd_ready", cmd_ready, exp_ready);
    chk("busy", busy, exp_q.size() != 0);
    chk("pending", pending_steps, m_pend);
    chk("err", err_underflow, m_err);
    hs = (exp_q.size() != 0) && rdy;
    if (m_axis_tvalid && m_axis_tready) hs_log.push_back(m_axis_tdata);
    @(posedge clk);
    add = '0;
    if (hs) begin
      pkt = exp_q.pop_front();
      if (pkt[15:13] == 3'b001) add = {19'd0, pkt[12:0]};
    end
    if (ob) begin
      if (m_pend == 0 && add == 0) m_err = 1'b1;
      else m_pend = m_pend + add - 1;
    end else begin
      m_pend = m_pend + add;
    end
    if (v && exp_ready) push_cmd(op, arg, cnt);
  endtask

  task automatic idle(input logic rdy, input logic ob);
    step(1'b0, 2'd0, '0, '0, rdy, ob);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    cmd_valid = 1'b0; out_beat = 1'b0; arst = 1'b1;
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_pending", pending_steps, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    m_pend = '0;
    m_err = 1'b0;
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    logic [31:0] rc;
    logic [1:0]  rop;
    do_reset();

    // Back-to-back CLR, PERIODIC, RUN 1 at full rate.
    hs_log.delete();
    step(1'b1, 2'd2, '0, '0, 1'b1, 1'b0);
    step(1'b1, 2'd3, 15'h0460, '0, 1'b1, 1'b0);
    step(1'b1, 2'd0, '0, 32'd1, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("t1_count", hs_log.size(), 3);
    chk("t1_pkt0", hs_log[0], 16'h6000);
    chk("t1_pkt1", hs_log[1], 16'h8460);
    chk("t1_pkt2", hs_log[2], 16'h2001);
    chk("t1_pending", pending_steps, 1);

    // RUN 20000 split into three packets.
    idle(1'b1, 1'b1);
    hs_log.delete();
    step(1'b1, 2'd0, '0, 32'd20000, 1'b1, 1'b0);
    #1;
    chk("t2_split_ready", cmd_ready, 0);
    for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
    #1;
    chk("t2_count", hs_log.size(), 3);
    chk("t2_pkt0", hs_log[0], 16'h3FFF);
    chk("t2_pkt1", hs_log[1], 16'h3FFF);
    chk("t2_pkt2", hs_log[2], 16'h2E22);
    chk("t2_pending", pending_steps, 20000);

    // SPIKE held under back-pressure.
    hs_log.delete();
    step(1'b1, 2'd1, 15'h0400, '0, 1'b0, 1'b0);
    #1;
    chk("t3_tdata", m_axis_tdata, 16'h4400);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("t3_count", hs_log.size(), 1);
    chk("t3_pkt", hs_log[0], 16'h4400);

    // RUN 0 emits nothing.
    hs_log.delete();
    step(1'b1, 2'd0, '0, 32'd0, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("t4_count", hs_log.size(), 0);
    chk("t4_pending", pending_steps, 20000);

    // Simultaneous RUN handshake and out_beat, then drain to underflow.
    do_reset();
    step(1'b1, 2'd0, '0, 32'd3, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("t5_pending3", pending_steps, 3);
    step(1'b1, 2'd0, '0, 32'd5, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    #1;
    chk("t5_pending7", pending_steps, 7);
    for (int i = 0; i < 7; i++) idle(1'b1, 1'b1);
    #1;
    chk("t5_pending0", pending_steps, 0);
    chk("t5_err0", err_underflow, 0);
    idle(1'b1, 1'b1);
    #1;
    chk("t5_err1", err_underflow, 1);
    chk("t5_pending_sat", pending_steps, 0);

    // Reset in the middle of a split.
    step(1'b1, 2'd0, '0, 32'd20000, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    do_reset();
    hs_log.delete();
    step(1'b1, 2'd0, '0, 32'd2, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    #1;
    chk("t6_count", hs_log.size(), 1);
    chk("t6_pkt", hs_log[0], 16'h2002);
    chk("t6_pending", pending_steps, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: rc = 32'd0;
        1: rc = 32'($urandom_range(1, 100));
        2: rc = 32'($urandom_range(8190, 8193));
        3: rc = 32'($urandom_range(16381, 16383));
        default: rc = 32'($urandom_range(1, 30000));
      endcase
      step($urandom_range(0, 1) == 1, rop, 15'($urandom), rc,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
